// File: rtl/dcp_serial_arbiter.sv
// -----------------------------------------------------------------------------
// dcp_serial_arbiter
//
// Purpose:
//   Shares one serial RX engine and one serial TX engine between up to N debug
//   command processors. Each processor drives req/type(/data) as if it owned
//   the engine. Two independent round-robin arbiters (RX path, TX path) pick
//   one owner each, forward that owner's signals to the engine, and route the
//   engine ack back to the owner only. A per-path watchdog force-releases a
//   grant that stays open too long and sets a sticky error flag.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   req_rx/type_rx         per-processor RX request / type (1 = hex, 0 = char)
//   ack_rx                 per-processor RX ack (only owner bit can be 1)
//   din_rx/flag_rx         RX engine word/flag broadcast to all processors
//   rx_req/rx_type         to RX engine
//   rx_ack/rx_din/rx_flag  from RX engine
//   req_tx/type_tx/dout    per-processor TX request / type / packed data
//   ack_tx                 per-processor TX ack (only owner bit can be 1)
//   tx_req/tx_type/tx_dout to TX engine
//   tx_ack                 from TX engine
//   rx_owner/tx_owner      current owner index (meaningful while busy)
//   rx_busy/tx_busy        grant open
//   timeout_err            sticky watchdog flag, cleared only by rst
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// dcp_arb_core: one round-robin arbiter with watchdog (used once per path).
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   req/type_in  per-processor request and type
//   ack          per-processor ack (engine ack steered to owner)
//   eng_req      request to engine (owner's req, masked on forced release)
//   eng_type     type to engine (owner's type, 0 when idle)
//   eng_ack      ack from engine
//   owner        current owner index
//   busy         grant open
//   force_rel    one-cycle pulse in the cycle the watchdog forces release
// -----------------------------------------------------------------------------
module dcp_arb_core #(
  parameter int N       = 4,
  parameter int TIMEOUT = 1048575
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic [N-1:0] type_in,
  output logic [N-1:0] ack,
  output logic         eng_req,
  output logic         eng_type,
  input  logic         eng_ack,
  output logic [2:0]   owner,
  output logic         busy,
  output logic         force_rel
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [19:0] WDOG_LAST = 20'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [2:0]  owner_q, owner_d;
  logic [2:0]  rr_ptr_q, rr_ptr_d;
  logic [19:0] wdog_q, wdog_d;

  // Requests and types widened to 8 entries so a 3-bit owner index can
  // select them directly; unused slots read as 0.
  logic [7:0] req_pad;
  logic [7:0] type_pad;

  for (genvar gi = 0; gi < 8; gi++) begin : g_pad
    if (gi < N) begin : g_used
      assign req_pad[gi]  = req[gi];
      assign type_pad[gi] = type_in[gi];
    end else begin : g_unused
      assign req_pad[gi]  = 1'b0;
      assign type_pad[gi] = 1'b0;
    end
  end

  // Modulo-N wrap of a value known to be below 2*N.
  function automatic logic [2:0] wrap_n(input logic [3:0] v);
    logic [3:0] r;
    r = (v >= 4'(N)) ? (v - 4'(N)) : v;
    return r[2:0];
  endfunction

  logic [2:0] owner_next;
  assign owner_next = wrap_n({1'b0, owner_q} + 4'd1);

  // Round-robin pick: scan rr_ptr, rr_ptr+1, ... and keep the first hit.
  // Walking the offsets from high to low lets the lowest offset win last.
  logic       pick_found;
  logic [2:0] pick_idx;
  logic [2:0] cand;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = 3'd0;
    cand       = 3'd0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = wrap_n({1'b0, rr_ptr_q} + 4'(k));
      if (req_pad[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  logic grant_open;
  assign grant_open = (state_q == GRANT);
  assign force_rel  = grant_open && (wdog_q == WDOG_LAST);

  // Engine side is a pure function of registered state and processor
  // inputs; eng_ack never feeds eng_req.
  assign busy     = grant_open;
  assign owner    = owner_q;
  assign eng_req  = grant_open && req_pad[owner_q] && !force_rel;
  assign eng_type = grant_open && type_pad[owner_q];

  for (genvar gi = 0; gi < N; gi++) begin : g_ack
    assign ack[gi] = grant_open && eng_ack && (owner_q == 3'(gi));
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    wdog_d   = wdog_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = GRANT;
          owner_d = pick_idx;
          wdog_d  = 20'd0;
        end
      end
      GRANT: begin
        // Release once the owner has withdrawn and the engine has dropped
        // ack; a stuck owner is cut loose by the watchdog instead.
        if (force_rel || (!req_pad[owner_q] && !eng_ack)) begin
          state_d  = IDLE;
          rr_ptr_d = owner_next;
        end else begin
          wdog_d = wdog_q + 20'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= 3'd0;
      rr_ptr_q <= 3'd0;
      wdog_q   <= 20'd0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      wdog_q   <= wdog_d;
    end
  end

endmodule

module dcp_serial_arbiter #(
  parameter int N       = 4,
  parameter int DW      = 32,
  parameter int TIMEOUT = 1048575
) (
  input  logic            clk,
  input  logic            rst,
  // RX side, processors
  input  logic [N-1:0]    req_rx,
  input  logic [N-1:0]    type_rx,
  output logic [N-1:0]    ack_rx,
  output logic [DW-1:0]   din_rx,
  output logic            flag_rx,
  // RX engine
  output logic            rx_req,
  output logic            rx_type,
  input  logic            rx_ack,
  input  logic [DW-1:0]   rx_din,
  input  logic            rx_flag,
  // TX side, processors
  input  logic [N-1:0]    req_tx,
  input  logic [N-1:0]    type_tx,
  input  logic [N*DW-1:0] dout,
  output logic [N-1:0]    ack_tx,
  // TX engine
  output logic            tx_req,
  output logic            tx_type,
  output logic [DW-1:0]   tx_dout,
  input  logic            tx_ack,
  // status
  output logic [2:0]      rx_owner,
  output logic [2:0]      tx_owner,
  output logic            rx_busy,
  output logic            tx_busy,
  output logic            timeout_err
);

  logic rx_force_rel;
  logic tx_force_rel;

  dcp_arb_core #(
    .N       (N),
    .TIMEOUT (TIMEOUT)
  ) u_rx_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_rx),
    .type_in   (type_rx),
    .ack       (ack_rx),
    .eng_req   (rx_req),
    .eng_type  (rx_type),
    .eng_ack   (rx_ack),
    .owner     (rx_owner),
    .busy      (rx_busy),
    .force_rel (rx_force_rel)
  );

  dcp_arb_core #(
    .N       (N),
    .TIMEOUT (TIMEOUT)
  ) u_tx_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_tx),
    .type_in   (type_tx),
    .ack       (ack_tx),
    .eng_req   (tx_req),
    .eng_type  (tx_type),
    .eng_ack   (tx_ack),
    .owner     (tx_owner),
    .busy      (tx_busy),
    .force_rel (tx_force_rel)
  );

  // RX data and flag go to every processor unregistered; each one only
  // consumes din_rx while its own ack_rx is high.
  assign din_rx  = rx_din;
  assign flag_rx = rx_flag;

  // Unpack TX data into 8 slots so the 3-bit owner selects directly.
  logic [DW-1:0] dout_arr [8];

  for (genvar gi = 0; gi < 8; gi++) begin : g_dout
    if (gi < N) begin : g_used
      assign dout_arr[gi] = dout[gi*DW +: DW];
    end else begin : g_unused
      assign dout_arr[gi] = '0;
    end
  end

  // Data to the TX engine is zero whenever no grant is open.
  assign tx_dout = tx_busy ? dout_arr[tx_owner] : '0;

  logic timeout_err_q, timeout_err_d;

  always_comb begin
    timeout_err_d = timeout_err_q | rx_force_rel | tx_force_rel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_err_q <= 1'b0;
    end else begin
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_dcp_serial_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dcp_serial_arbiter
//
// Directed scenarios followed by a random phase. Processor agents and engine
// agents are simple 4-phase handshake behaviours; every DUT output is compared
// each cycle against a transaction-level model of the two arbiters (grant
// open/closed, owner, round-robin start, watchdog age, sticky error).
// -----------------------------------------------------------------------------
module tb_dcp_serial_arbiter;

  localparam int N       = 4;
  localparam int DW      = 32;
  localparam int TIMEOUT = 32;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_rx, type_rx, ack_rx;
  logic [DW-1:0]   din_rx;
  logic            flag_rx;
  logic            rx_req, rx_type, rx_ack;
  logic [DW-1:0]   rx_din;
  logic            rx_flag;
  logic [N-1:0]    req_tx, type_tx, ack_tx;
  logic [N*DW-1:0] dout;
  logic            tx_req, tx_type;
  logic [DW-1:0]   tx_dout;
  logic            tx_ack;
  logic [2:0]      rx_owner, tx_owner;
  logic            rx_busy, tx_busy;
  logic            timeout_err;

  dcp_serial_arbiter #(
    .N       (N),
    .DW      (DW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_rx      (req_rx),
    .type_rx     (type_rx),
    .ack_rx      (ack_rx),
    .din_rx      (din_rx),
    .flag_rx     (flag_rx),
    .rx_req      (rx_req),
    .rx_type     (rx_type),
    .rx_ack      (rx_ack),
    .rx_din      (rx_din),
    .rx_flag     (rx_flag),
    .req_tx      (req_tx),
    .type_tx     (type_tx),
    .dout        (dout),
    .ack_tx      (ack_tx),
    .tx_req      (tx_req),
    .tx_type     (tx_type),
    .tx_dout     (tx_dout),
    .tx_ack      (tx_ack),
    .rx_owner    (rx_owner),
    .tx_owner    (tx_owner),
    .rx_busy     (rx_busy),
    .tx_busy     (tx_busy),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: index 0 = RX path, 1 = TX path.
  bit       m_open [2];
  bit [1:0] m_who  [2];
  bit [1:0] m_ptr  [2];
  int       m_wd   [2];
  bit       m_terr;

  // Expected outputs from the last sample, used by the agents.
  logic [N-1:0] e_ack_rx, e_ack_tx;
  logic         e_rx_req, e_tx_req;

  // Agent controls.
  bit rand_new = 0;
  bit hold_rx  = 0;
  bit hold_tx  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit [1:0] rr_pick(input bit [1:0] ptr, input logic [N-1:0] r);
    for (int k = 0; k < N; k++) begin
      bit [1:0] idx;
      idx = 2'((int'(ptr) + k) % N);
      if (r[idx]) return idx;
    end
    return 2'd0;
  endfunction

  task automatic model_path(input int p, input logic [N-1:0] r, input logic a);
    if (!m_open[p]) begin
      if (r != '0) begin
        m_who[p]  = rr_pick(m_ptr[p], r);
        m_open[p] = 1'b1;
        m_wd[p]   = 0;
      end
    end else if (m_wd[p] == TIMEOUT - 1) begin
      m_open[p] = 1'b0;
      m_ptr[p]  = 2'((int'(m_who[p]) + 1) % N);
      m_terr    = 1'b1;
    end else if (!r[m_who[p]] && !a) begin
      m_open[p] = 1'b0;
      m_ptr[p]  = 2'((int'(m_who[p]) + 1) % N);
    end else begin
      m_wd[p]++;
    end
  endtask

  // Compare all outputs at the falling edge against the model.
  task automatic sample();
    logic          x_rxr, x_txr, x_rxt, x_txt;
    logic [N-1:0]  x_ackr, x_ackt;
    logic [DW-1:0] x_dout;
    @(negedge clk);
    x_rxr  = m_open[0] && req_rx[m_who[0]] && (m_wd[0] != TIMEOUT - 1);
    x_txr  = m_open[1] && req_tx[m_who[1]] && (m_wd[1] != TIMEOUT - 1);
    x_rxt  = m_open[0] && type_rx[m_who[0]];
    x_txt  = m_open[1] && type_tx[m_who[1]];
    x_ackr = m_open[0] ? (N'(rx_ack) << m_who[0]) : '0;
    x_ackt = m_open[1] ? (N'(tx_ack) << m_who[1]) : '0;
    x_dout = m_open[1] ? dout[int'(m_who[1])*DW +: DW] : '0;
    chk("rx_busy",     64'(rx_busy),     64'(m_open[0]));
    chk("tx_busy",     64'(tx_busy),     64'(m_open[1]));
    chk("rx_req",      64'(rx_req),      64'(x_rxr));
    chk("tx_req",      64'(tx_req),      64'(x_txr));
    chk("rx_type",     64'(rx_type),     64'(x_rxt));
    chk("tx_type",     64'(tx_type),     64'(x_txt));
    chk("ack_rx",      64'(ack_rx),      64'(x_ackr));
    chk("ack_tx",      64'(ack_tx),      64'(x_ackt));
    chk("tx_dout",     64'(tx_dout),     64'(x_dout));
    chk("din_rx",      64'(din_rx),      64'(rx_din));
    chk("flag_rx",     64'(flag_rx),     64'(rx_flag));
    chk("timeout_err", 64'(timeout_err), 64'(m_terr));
    if (m_open[0]) chk("rx_owner", 64'(rx_owner), 64'(m_who[0]));
    if (m_open[1]) chk("tx_owner", 64'(tx_owner), 64'(m_who[1]));
    e_ack_rx = x_ackr;
    e_ack_tx = x_ackt;
    e_rx_req = x_rxr;
    e_tx_req = x_txr;
  endtask

  // Clock edge: advance the model, then let the agents react.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int p = 0; p < 2; p++) begin
        m_open[p] = 1'b0;
        m_who[p]  = 2'd0;
        m_ptr[p]  = 2'd0;
        m_wd[p]   = 0;
      end
      m_terr = 1'b0;
    end else begin
      model_path(0, req_rx, rx_ack);
      model_path(1, req_tx, tx_ack);
    end
    #1;
    for (int i = 0; i < N; i++) begin
      if (req_rx[i] && e_ack_rx[i]) req_rx[i] = 1'b0;
      else if (rand_new && !req_rx[i] && !e_ack_rx[i] && $urandom_range(3) == 0) begin
        req_rx[i]  = 1'b1;
        type_rx[i] = 1'($urandom);
      end else if (rand_new && req_rx[i] && !e_ack_rx[i] && $urandom_range(63) == 0)
        req_rx[i] = 1'b0;
      if (req_tx[i] && e_ack_tx[i]) req_tx[i] = 1'b0;
      else if (rand_new && !req_tx[i] && !e_ack_tx[i] && $urandom_range(3) == 0) begin
        req_tx[i]          = 1'b1;
        type_tx[i]         = 1'($urandom);
        dout[i*DW +: DW]   = $urandom;
      end else if (rand_new && req_tx[i] && !e_ack_tx[i] && $urandom_range(63) == 0)
        req_tx[i] = 1'b0;
    end
    if (rx_ack && !e_rx_req) rx_ack = 1'b0;
    else if (!rx_ack && e_rx_req && !hold_rx && (!rand_new || $urandom_range(1) == 0)) rx_ack = 1'b1;
    if (tx_ack && !e_tx_req) tx_ack = 1'b0;
    else if (!tx_ack && e_tx_req && !hold_tx && (!rand_new || $urandom_range(1) == 0)) tx_ack = 1'b1;
    rx_din  = $urandom;
    rx_flag = 1'($urandom);
  endtask

  task automatic run(input int n);
    repeat (n) begin
      sample();
      tick();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run(2);
    rst = 1'b0;
  endtask

  initial begin
    int order [$];
    logic prev_busy;
    logic prev_ack;
    int acks;
    int started;
    int busy_cnt;
    bit done;

    rst = 1'b1;
    req_rx = '0; type_rx = '0; rx_ack = 1'b0; rx_din = '0; rx_flag = 1'b0;
    req_tx = '0; type_tx = '0; tx_ack = 1'b0; dout = '0;
    e_ack_rx = '0; e_ack_tx = '0; e_rx_req = 1'b0; e_tx_req = 1'b0;
    m_terr = 1'b0;
    for (int p = 0; p < 2; p++) begin
      m_open[p] = 1'b0; m_who[p] = 2'd0; m_ptr[p] = 2'd0; m_wd[p] = 0;
    end

    // Reset values
    run(3);
    sample();
    chk("rst_tx_req",  64'(tx_req),      64'd0);
    chk("rst_ack_tx",  64'(ack_tx),      64'd0);
    chk("rst_busy",    64'({rx_busy, tx_busy}), 64'd0);
    chk("rst_tx_dout", 64'(tx_dout),     64'd0);
    chk("rst_terr",    64'(timeout_err), 64'd0);
    tick();
    rst = 1'b0;
    run(2);

    // Single requester on TX
    req_tx[1] = 1'b1; type_tx[1] = 1'b0; dout[1*DW +: DW] = 32'h49;
    sample(); chk("single_idle", 64'(tx_busy), 64'd0); tick();
    sample();
    chk("single_tx_req",  64'(tx_req),   64'd1);
    chk("single_tx_dout", 64'(tx_dout),  64'h49);
    chk("single_owner",   64'(tx_owner), 64'd1);
    tick();
    sample(); chk("single_ack", 64'(ack_tx), 64'b0010); tick();
    run(2);
    sample(); chk("single_release", 64'(tx_busy), 64'd0); tick();

    // Round-robin resumes after owner 1: of {0,3}, 3 is next
    req_tx = 4'b1001;
    sample(); tick();
    sample(); chk("rr_after_1", 64'(tx_owner), 64'd3); tick();
    run(20);

    // Contention after reset: order 0,1,3
    do_reset();
    req_tx = 4'b1011;
    prev_busy = 1'b0;
    for (int c = 0; c < 30; c++) begin
      sample();
      if (tx_busy && !prev_busy) order.push_back(int'(tx_owner));
      prev_busy = tx_busy;
      tick();
    end
    chk("contend_count", 64'(order.size()), 64'd3);
    if (order.size() == 3) begin
      chk("contend_1st", 64'(order[0]), 64'd0);
      chk("contend_2nd", 64'(order[1]), 64'd1);
      chk("contend_3rd", 64'(order[2]), 64'd3);
    end

    // Independence: RX held by processor 2 while processor 0 sends 3 chars
    do_reset();
    hold_rx = 1'b1;
    req_rx[2] = 1'b1;
    started = 0; acks = 0; prev_ack = 1'b0;
    for (int c = 0; c < 25; c++) begin
      if (started < 3 && !req_tx[0] && !e_ack_tx[0]) begin
        req_tx[0] = 1'b1;
        dout[0 +: DW] = $urandom;
        started++;
      end
      sample();
      if (c > 0) chk("indep_rx_owner", 64'({rx_busy, rx_owner}), 64'({1'b1, 3'd2}));
      if (ack_tx[0] && !prev_ack) acks++;
      prev_ack = ack_tx[0];
      tick();
    end
    chk("indep_tx_chars", 64'(acks), 64'd3);
    req_rx[2] = 1'b0;
    run(4);

    // Early withdrawal: owner 0 drops before any ack, processor 2 next
    req_rx = 4'b0101;
    sample(); tick();
    sample(); chk("wd_owner0", 64'({rx_req, rx_owner}), 64'({1'b1, 3'd0})); tick();
    req_rx[0] = 1'b0;
    sample(); tick();
    sample(); chk("wd_released", 64'(rx_busy), 64'd0); tick();
    sample();
    chk("wd_owner2", 64'(rx_owner), 64'd2);
    chk("wd_no_ack", 64'(ack_rx),   64'd0);
    tick();
    hold_rx = 1'b0;
    run(10);

    // Reset while tx_ack is high
    req_tx[1] = 1'b1;
    for (int c = 0; c < 10 && !tx_ack; c++) run(1);
    chk("mid_ack_seen", 64'(tx_ack), 64'd1);
    rst = 1'b1;
    sample(); tick();
    tx_ack = 1'b1;
    sample();
    chk("mid_rst_ack",  64'(ack_tx),  64'd0);
    chk("mid_rst_req",  64'(tx_req),  64'd0);
    chk("mid_rst_busy", 64'(tx_busy), 64'd0);
    tick();
    rst = 1'b0; tx_ack = 1'b0; req_tx = 4'b1001;
    sample(); tick();
    sample(); chk("mid_rst_ptr0", 64'(tx_owner), 64'd0); tick();
    run(20);

    // Watchdog: owner 2 holds req, TX engine never acks
    hold_tx = 1'b1;
    req_tx[2] = 1'b1;
    busy_cnt = 0; done = 1'b0;
    for (int c = 0; c < 80; c++) begin
      sample();
      if (!done) begin
        if (tx_busy) busy_cnt++;
        else if (busy_cnt > 0) done = 1'b1;
      end
      tick();
    end
    chk("wdog_cycles", 64'(busy_cnt), 64'(TIMEOUT));
    req_tx = '0; hold_tx = 1'b0;
    run(3);
    sample(); chk("wdog_sticky", 64'(timeout_err), 64'd1); tick();
    do_reset();
    sample(); chk("wdog_cleared", 64'(timeout_err), 64'd0); tick();

    // Random traffic on both paths
    rand_new = 1'b1;
    run(3000);
    rand_new = 1'b0;
    req_rx = '0; req_tx = '0;
    run(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
